// File: rtl/audio_adc_i2s_rx.sv
// Purpose : deserialize codec I2S ADC data into stereo pairs and queue them for the record path.
// Latency : pair enters the FIFO 1 clk after the rise that ends its right slot; valid one clk later.
// Backpr. : valid/ready pop; holds the head while ~ready; pair dropped (sticky overflow) when full.
module audio_adc_i2s_rx #(
   parameter int DATA_W     = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk_clk,
   input  logic              reset_reset,
   input  logic              audio_BCLK,
   input  logic              audio_ADCLRCK,
   input  logic              audio_ADCDAT,
   input  logic              enable,
   output logic [DATA_W-1:0] sample_left,
   output logic [DATA_W-1:0] sample_right,
   output logic              sample_valid,
   input  logic              sample_ready,
   output logic              overflow,
   input  logic              clear_overflow
);

   localparam int CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int PAIR_W = 2 * DATA_W;
   localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_W - 1);
   localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_SHIFT, ST_HOLD} state_t;

   // synchronizers and edge history
   logic bclk_s1_q, bclk_s2_q, bclk_h_q;
   logic lrck_s1_q, lrck_s2_q, lrck_h_q;
   logic dat_s1_q, dat_s2_q;

   // slot deserializer
   state_t            state_q, state_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [CNT_W-1:0]  bit_idx;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [DATA_W-1:0] left_hold_q, left_hold_d;
   logic              left_vld_q, left_vld_d;
   logic              push_q, push_d;
   logic [PAIR_W-1:0] pair_q, pair_d;

   // pair FIFO
   logic [PAIR_W-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]    count_q;
   logic              overflow_q;
   logic              fifo_full, fifo_pop, fifo_wr, fifo_drop;

   logic bclk_rise, lrck_edge;

   // LRCK history is taken at BCLK rises so an edge is always seen on the rise that follows it
   assign bclk_rise = bclk_s2_q & ~bclk_h_q;
   assign lrck_edge = bclk_rise & (lrck_s2_q ^ lrck_h_q);
   assign bit_idx   = LAST_BIT - bit_cnt_q;

   // bring the codec pins into clk_clk; all three share the same stage depth to stay aligned
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         bclk_s1_q <= 1'b0;
         bclk_s2_q <= 1'b0;
         bclk_h_q  <= 1'b0;
         lrck_s1_q <= 1'b0;
         lrck_s2_q <= 1'b0;
         lrck_h_q  <= 1'b0;
         dat_s1_q  <= 1'b0;
         dat_s2_q  <= 1'b0;
      end else begin
         bclk_s1_q <= audio_BCLK;
         bclk_s2_q <= bclk_s1_q;
         bclk_h_q  <= bclk_s2_q;
         lrck_s1_q <= audio_ADCLRCK;
         lrck_s2_q <= lrck_s1_q;
         dat_s1_q  <= audio_ADCDAT;
         dat_s2_q  <= dat_s1_q;
         if (bclk_rise) begin
            lrck_h_q <= lrck_s2_q;
         end
      end
   end

   // slot FSM state and datapath registers
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         left_hold_q <= '0;
         left_vld_q  <= 1'b0;
         push_q      <= 1'b0;
         pair_q      <= '0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         left_hold_q <= left_hold_d;
         left_vld_q  <= left_vld_d;
         push_q      <= push_d;
         pair_q      <= pair_d;
      end
   end

   // slot sequencing: LRCK edge closes a slot (word is MSB-aligned, unfilled LSBs stay zero)
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      left_hold_d = left_hold_q;
      left_vld_d  = left_vld_q;
      push_d      = 1'b0;
      pair_d      = pair_q;
      if (!enable) begin
         state_d    = ST_IDLE;
         left_vld_d = 1'b0;
      end else if (state_q == ST_IDLE) begin
         // only a 1->0 edge (start of a left slot) brings the capture out of idle
         if (lrck_edge && !lrck_s2_q) begin
            state_d    = ST_DELAY;
            shift_d    = '0;
            bit_cnt_d  = '0;
            left_vld_d = 1'b0;
         end
      end else if (lrck_edge) begin
         if (lrck_s2_q) begin
            left_hold_d = shift_q;
            left_vld_d  = 1'b1;
         end else begin
            // a right word without a left partner from this run is never queued
            push_d     = left_vld_q;
            pair_d     = {left_hold_q, shift_q};
            left_vld_d = 1'b0;
         end
         state_d   = ST_DELAY;
         shift_d   = '0;
         bit_cnt_d = '0;
      end else if (bclk_rise) begin
         case (state_q)
            ST_DELAY: state_d = ST_SHIFT;
            ST_SHIFT: begin
               shift_d[bit_idx] = dat_s2_q;
               bit_cnt_d        = bit_cnt_q + CNT_W'(1);
               if (bit_cnt_q == LAST_BIT) begin
                  state_d = ST_HOLD;
               end
            end
            default: ;
         endcase
      end
   end

   assign sample_valid = (count_q != '0);
   assign fifo_full    = (count_q == FIFO_FULL);
   assign fifo_pop     = sample_valid & sample_ready;
   assign fifo_wr      = push_q & (~fifo_full | fifo_pop);
   assign fifo_drop    = push_q & fifo_full & ~fifo_pop;

   // FIFO pointers, occupancy and sticky overflow (a new drop beats a clear)
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (fifo_wr) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (fifo_pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         if (fifo_wr && !fifo_pop) begin
            count_q <= count_q + (PTR_W + 1)'(1);
         end else if (!fifo_wr && fifo_pop) begin
            count_q <= count_q - (PTR_W + 1)'(1);
         end
         if (fifo_drop) begin
            overflow_q <= 1'b1;
         end else if (clear_overflow) begin
            overflow_q <= 1'b0;
         end
      end
   end

   // FIFO storage; contents only matter behind the valid count
   always_ff @(posedge clk_clk) begin
      if (fifo_wr) begin
         mem_q[wr_ptr_q] <= pair_q;
      end
   end

   assign {sample_left, sample_right} = sample_valid ? mem_q[rd_ptr_q] : '0;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_audio_adc_i2s_rx.sv
// Bench for audio_adc_i2s_rx: drives I2S frames (8 clk per BCLK) and scores popped pairs.
// Expected pairs are queued when frames are issued; a monitor pops and compares on valid & ready.
// Each slot: rise 0 shows the new LRCK level, rise 1 is the delay bit, data MSB-first from rise 2.
module tb_audio_adc_i2s_rx;

   logic        clk_clk;
   logic        reset_reset;
   logic        audio_BCLK;
   logic        audio_ADCLRCK;
   logic        audio_ADCDAT;
   logic        enable;
   logic [15:0] sample_left;
   logic [15:0] sample_right;
   logic        sample_valid;
   logic        sample_ready;
   logic        overflow;
   logic        clear_overflow;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];

   logic [15:0] t3_l [5] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
   logic [15:0] t3_r [5] = '{16'h9001, 16'h9002, 16'h9003, 16'h9004, 16'h9005};
   logic [15:0] t4_l [5] = '{16'hF00D, 16'h0001, 16'h8000, 16'h7FFE, 16'hC3C3};
   logic [15:0] t4_r [5] = '{16'h1234, 16'hFFFF, 16'h0000, 16'h5A5A, 16'h3C3C};

   audio_adc_i2s_rx #(.DATA_W(16), .FIFO_DEPTH(4)) dut (
      .clk_clk        (clk_clk),
      .reset_reset    (reset_reset),
      .audio_BCLK     (audio_BCLK),
      .audio_ADCLRCK  (audio_ADCLRCK),
      .audio_ADCDAT   (audio_ADCDAT),
      .enable         (enable),
      .sample_left    (sample_left),
      .sample_right   (sample_right),
      .sample_valid   (sample_valid),
      .sample_ready   (sample_ready),
      .overflow       (overflow),
      .clear_overflow (clear_overflow)
   );

   initial begin
      clk_clk = 1'b0;
      forever #5 clk_clk = ~clk_clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no end of stimulus, required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   // one BCLK period: LRCK/DAT change while BCLK is low, rise after 4 clk
   task automatic bclk_cycle(input logic lr, input logic d);
      audio_BCLK    = 1'b0;
      audio_ADCLRCK = lr;
      audio_ADCDAT  = d;
      repeat (4) @(negedge clk_clk);
      audio_BCLK = 1'b1;
      repeat (4) @(negedge clk_clk);
   endtask

   // total rises in the slot; bits beyond nbits are driven 1 so they must be ignored
   task automatic slot(input logic lr, input logic [15:0] w, input int nbits, input int total);
      logic d;
      for (int k = 0; k < total; k++) begin
         if (k < 2)               d = 1'b0;
         else if (k - 2 < nbits)  d = w[15 - (k - 2)];
         else                     d = 1'b1;
         bclk_cycle(lr, d);
      end
   endtask

   task automatic frame(input logic [15:0] l, input logic [15:0] r, input int total, input bit expect_out);
      if (expect_out) exp_q.push_back({l, r});
      slot(1'b0, l, 16, total);
      slot(1'b1, r, 16, total);
   endtask

   task automatic preamble();
      slot(1'b1, 16'h0000, 0, 3);
   endtask

   // close the last right slot with an LRCK fall, then abort the dangling left slot
   task automatic end_burst();
      slot(1'b0, 16'h0000, 0, 3);
      enable = 1'b0;
      repeat (3) @(negedge clk_clk);
      enable = 1'b1;
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clk_clk);
      check(name, exp_q.size(), 32'd0);
      repeat (4) @(negedge clk_clk);
   endtask

   // monitor: pops expected pairs on valid & ready and checks the head holds while stalled
   initial begin
      logic        prev_hold;
      logic [31:0] prev_dat;
      logic [31:0] e;
      prev_hold = 1'b0;
      prev_dat  = '0;
      forever begin
         @(negedge clk_clk);
         #2;
         if (reset_reset) begin
            prev_hold = 1'b0;
         end else begin
            if (prev_hold && sample_valid) begin
               check("hold_stable", {sample_left, sample_right}, prev_dat);
            end
            if (sample_valid && sample_ready) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_pair", {sample_left, sample_right}, 32'hxxxx_xxxx);
               end else begin
                  e = exp_q.pop_front();
                  check("pair", {sample_left, sample_right}, e);
               end
            end
            prev_hold = sample_valid && !sample_ready;
            prev_dat  = {sample_left, sample_right};
         end
      end
   end

   initial begin
      reset_reset    = 1'b1;
      enable         = 1'b1;
      audio_BCLK     = 1'b0;
      audio_ADCLRCK  = 1'b1;
      audio_ADCDAT   = 1'b0;
      sample_ready   = 1'b0;
      clear_overflow = 1'b0;
      repeat (3) @(negedge clk_clk);
      #1;
      check("rst_valid", {31'h0, sample_valid}, 32'd0);
      check("rst_left", {16'h0, sample_left}, 32'd0);
      check("rst_right", {16'h0, sample_right}, 32'd0);
      check("rst_overflow", {31'h0, overflow}, 32'd0);
      reset_reset = 1'b0;
      @(negedge clk_clk);

      // full 32-BCLK slots
      sample_ready = 1'b1;
      preamble();
      frame(16'hA5C3, 16'h0F01, 32, 1'b1);
      end_burst();
      wait_drain("t1_drain");

      // 12-bit left slot zero-padded; zero-bit left slot (edge while in DELAY) gives 0
      preamble();
      exp_q.push_back({16'hABC0, 16'h8001});
      slot(1'b0, 16'hABC0, 12, 14);
      slot(1'b1, 16'h8001, 16, 32);
      exp_q.push_back({16'h0000, 16'h7FFF});
      slot(1'b0, 16'hFFFF, 0, 1);
      slot(1'b1, 16'h7FFF, 16, 18);
      end_burst();
      wait_drain("t2_drain");

      // five pairs into a stalled 4-deep FIFO: fifth dropped
      sample_ready = 1'b0;
      preamble();
      for (int i = 0; i < 5; i++) frame(t3_l[i], t3_r[i], 18, i < 4);
      end_burst();
      repeat (10) @(negedge clk_clk);
      #1;
      check("t3_overflow_set", {31'h0, overflow}, 32'd1);
      check("t3_valid", {31'h0, sample_valid}, 32'd1);
      check("t3_head_left", {16'h0, sample_left}, {16'h0, t3_l[0]});
      clear_overflow = 1'b1;
      @(negedge clk_clk);
      clear_overflow = 1'b0;
      #1;
      check("t3_overflow_clear", {31'h0, overflow}, 32'd0);
      sample_ready = 1'b1;
      wait_drain("t3_drain");

      // FIFO full; ready opens in the cycle the fifth pair is written
      sample_ready = 1'b0;
      preamble();
      for (int i = 0; i < 5; i++) frame(t4_l[i], t4_r[i], 18, 1'b1);
      audio_BCLK    = 1'b0;
      audio_ADCLRCK = 1'b0;
      audio_ADCDAT  = 1'b0;
      repeat (4) @(negedge clk_clk);
      audio_BCLK = 1'b1;
      repeat (3) @(negedge clk_clk);
      sample_ready = 1'b1;
      @(negedge clk_clk);
      bclk_cycle(1'b0, 1'b0);
      bclk_cycle(1'b0, 1'b0);
      enable = 1'b0;
      repeat (3) @(negedge clk_clk);
      enable = 1'b1;
      wait_drain("t4_drain");
      check("t4_no_overflow", {31'h0, overflow}, 32'd0);

      // enable dropped mid left slot: partial frame discarded
      preamble();
      frame(16'h1357, 16'h2468, 18, 1'b1);
      slot(1'b0, 16'hDEAD, 16, 10);
      enable = 1'b0;
      repeat (10) @(negedge clk_clk);
      enable = 1'b1;
      preamble();
      frame(16'hCAFE, 16'hBEEF, 18, 1'b1);
      end_burst();
      wait_drain("t5_drain");

      // reset mid frame with two pairs queued
      sample_ready = 1'b0;
      preamble();
      frame(16'h0A0A, 16'h0B0B, 18, 1'b1);
      frame(16'h0C0C, 16'h0D0D, 18, 1'b1);
      slot(1'b0, 16'h5555, 16, 18);
      slot(1'b1, 16'hAAAA, 16, 8);
      #1;
      check("t6_queued_valid", {31'h0, sample_valid}, 32'd1);
      reset_reset = 1'b1;
      exp_q.delete();
      @(negedge clk_clk);
      #1;
      check("t6_rst_valid", {31'h0, sample_valid}, 32'd0);
      check("t6_rst_left", {16'h0, sample_left}, 32'd0);
      check("t6_rst_right", {16'h0, sample_right}, 32'd0);
      check("t6_rst_overflow", {31'h0, overflow}, 32'd0);
      reset_reset  = 1'b0;
      sample_ready = 1'b1;
      @(negedge clk_clk);
      preamble();
      frame(16'h0123, 16'h4567, 18, 1'b1);
      end_burst();
      wait_drain("t6_drain");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
